// File: rtl/game_sequencer_pkg.sv
// Shared game definitions: state encoding, score width and the saturating score helper.
package game_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_PLAY      = 2'b01,
        ST_GAME_OVER = 2'b11
    } game_state_t;

    localparam int SCORE_W = 8;
    localparam int CNT_W   = 8;

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] value);
        return (value == SCORE_MAX) ? value : value + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Bus between the game sequencer and the video, snake and apple-position logic.
interface game_sequencer_if;

    logic                                   frame_tick;
    logic                                   btn_any;
    logic                                   hit_wall_or_body;
    logic                                   hit_apple;
    logic                                   apple_ack;
    logic                                   apple_req;
    logic [1:0]                             game_state;
    logic                                   snake_step;
    logic                                   snake_grow;
    logic                                   snake_clear;
    logic [game_sequencer_pkg::SCORE_W-1:0] score;

    // The sequencer side: owns the apple request and all game-control outputs.
    modport master (
        input  frame_tick, btn_any, hit_wall_or_body, hit_apple, apple_ack,
        output apple_req, game_state, snake_step, snake_grow, snake_clear, score
    );

    // The surrounding game logic side.
    modport slave (
        output frame_tick, btn_any, hit_wall_or_body, hit_apple, apple_ack,
        input  apple_req, game_state, snake_step, snake_grow, snake_clear, score
    );

endinterface

// File: rtl/game_sequencer_frame_divider.sv
// Frame divider: down-counts frame ticks per snake step and shortens the step
// period by one frame every APPLES_PER_LEVEL apples, floored at FRAMES_MIN.
module game_sequencer_frame_divider
    import game_sequencer_pkg::*;
#(
    parameter int FRAMES_INIT      = 8,
    parameter int FRAMES_MIN       = 2,
    parameter int APPLES_PER_LEVEL = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic tick,
    input  logic apple,
    output logic step_due
);

    localparam int LW = (APPLES_PER_LEVEL > 1) ? $clog2(APPLES_PER_LEVEL) : 1;

    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] count;
    logic [LW-1:0]    level_cnt;

    // A step is due on the tick that finds the counter at its terminal count.
    assign step_due = tick && (count == CNT_W'(1));

    // Frame counter reload and speed-up level tracking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period    <= CNT_W'(FRAMES_INIT);
            count     <= CNT_W'(FRAMES_INIT);
            level_cnt <= '0;
        end else if (start) begin
            period    <= CNT_W'(FRAMES_INIT);
            count     <= CNT_W'(FRAMES_INIT);
            level_cnt <= '0;
        end else begin
            if (tick) begin
                count <= step_due ? period : count - CNT_W'(1);
            end
            if (apple) begin
                if (level_cnt == LW'(APPLES_PER_LEVEL - 1)) begin
                    level_cnt <= '0;
                    if (period > CNT_W'(FRAMES_MIN)) begin
                        period <= period - CNT_W'(1);
                    end
                end else begin
                    level_cnt <= level_cnt + LW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Game sequencer: top-level IDLE/PLAY/GAME_OVER control for the snake game.
//
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   ST_IDLE      | waiting for any button; score of the last game stays shown
//   ST_PLAY      | stepping the snake, latching hits, scoring apples
//   ST_GAME_OVER | collision seen; inputs ignored for OVER_FRAMES frames
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int FRAMES_INIT      = 8,
    parameter int FRAMES_MIN       = 2,
    parameter int APPLES_PER_LEVEL = 4,
    parameter int OVER_FRAMES      = 120
) (
    input  logic              clk,
    input  logic              reset,
    game_sequencer_if.master  bus
);

    localparam int OVER_W = $clog2(OVER_FRAMES + 1);

    game_state_t        state;
    logic               hit_flag;
    logic               apple_flag;
    logic               grow_pending;
    logic [OVER_W-1:0]  over_cnt;
    logic [SCORE_W-1:0] score;
    logic               apple_req;
    logic               snake_step;
    logic               snake_grow;
    logic               snake_clear;

    logic in_play;
    logic hit_now;
    logic apple_now;
    logic start_game;
    logic tick_play;
    logic eat;
    logic step_due;

    // Current-cycle view of the sticky flags, so a hit on the tick cycle itself counts.
    // Apples seen while a position request is outstanding are dropped.
    always_comb begin
        in_play    = (state == ST_PLAY);
        hit_now    = hit_flag | bus.hit_wall_or_body;
        apple_now  = apple_flag | (bus.hit_apple & ~apple_req);
        start_game = (state == ST_IDLE) && bus.btn_any;
        tick_play  = in_play && bus.frame_tick && !hit_now;
        eat        = tick_play && apple_now;
    end

    game_sequencer_frame_divider #(
        .FRAMES_INIT      (FRAMES_INIT),
        .FRAMES_MIN       (FRAMES_MIN),
        .APPLES_PER_LEVEL (APPLES_PER_LEVEL)
    ) u_frame_divider (
        .clk      (clk),
        .reset    (reset),
        .start    (start_game),
        .tick     (tick_play),
        .apple    (eat),
        .step_due (step_due)
    );

    // Main FSM with registered outputs; a collision on the tick overrides an apple.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            hit_flag     <= 1'b0;
            apple_flag   <= 1'b0;
            grow_pending <= 1'b0;
            over_cnt     <= '0;
            score        <= '0;
            apple_req    <= 1'b0;
            snake_step   <= 1'b0;
            snake_grow   <= 1'b0;
            snake_clear  <= 1'b0;
        end else begin
            snake_step  <= 1'b0;
            snake_grow  <= 1'b0;
            snake_clear <= 1'b0;
            if (apple_req && bus.apple_ack) begin
                apple_req <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.btn_any) begin
                        state        <= ST_PLAY;
                        snake_clear  <= 1'b1;
                        apple_req    <= 1'b1;
                        score        <= '0;
                        grow_pending <= 1'b0;
                        hit_flag     <= 1'b0;
                        apple_flag   <= 1'b0;
                    end
                end

                ST_PLAY: begin
                    if (bus.frame_tick) begin
                        hit_flag   <= 1'b0;
                        apple_flag <= 1'b0;
                        if (hit_now) begin
                            state        <= ST_GAME_OVER;
                            over_cnt     <= OVER_W'(OVER_FRAMES);
                            grow_pending <= 1'b0;
                        end else begin
                            if (apple_now) begin
                                score     <= score_inc(score);
                                apple_req <= 1'b1;
                            end
                            if (step_due) begin
                                snake_step   <= 1'b1;
                                snake_grow   <= grow_pending | apple_now;
                                grow_pending <= 1'b0;
                            end else if (apple_now) begin
                                grow_pending <= 1'b1;
                            end
                        end
                    end else begin
                        hit_flag   <= hit_now;
                        apple_flag <= apple_now;
                    end
                end

                ST_GAME_OVER: begin
                    if (bus.frame_tick) begin
                        if (over_cnt == OVER_W'(1)) begin
                            state <= ST_IDLE;
                        end else begin
                            over_cnt <= over_cnt - OVER_W'(1);
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.game_state  = state;
    assign bus.score       = score;
    assign bus.apple_req   = apple_req;
    assign bus.snake_step  = snake_step;
    assign bus.snake_grow  = snake_grow;
    assign bus.snake_clear = snake_clear;

endmodule
